// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory unit: access sizes, direction and FSM states.
// The misalignment helper is kept here so that every user applies the same legality rule.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  // The illegal size code is reported as an error, the same way a misalignment is.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return (offset != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the big-endian data memory: merges write data into the
// addressed lanes of the stored word and extracts/extends read data from them.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged_word,
  output logic [31:0] read_data
);

  logic [4:0] byte_shift;
  logic [4:0] half_shift;

  // Big-endian: offset 0 is the most significant lane, so the bit position is (3 - offset) * 8.
  assign byte_shift = {~offset, 3'b000};
  assign half_shift = {~offset[1], 4'b0000};

  always_comb begin
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    merged_word = old_word;
    read_data   = '0;
    byte_val    = old_word[byte_shift +: 8];
    half_val    = old_word[half_shift +: 16];
    case (size)
      SZ_BYTE: begin
        merged_word[byte_shift +: 8] = wdata[7:0];
        read_data = {{24{sign_ext & byte_val[7]}}, byte_val};
      end
      SZ_HALF: begin
        merged_word[half_shift +: 16] = wdata[15:0];
        read_data = {{16{sign_ext & half_val[15]}}, half_val};
      end
      SZ_WORD: begin
        merged_word = wdata;
        read_data   = old_word;
      end
      default: begin
        merged_word = old_word;
        read_data   = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Word-organised data memory with byte/halfword/word access, programmable wait states and a
// fixed-latency request/done handshake. Errors complete normally but never touch the array.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LAST = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t        state;
  state_t        state_next;
  logic [3:0]    wait_cnt;
  logic          accept;

  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic          rw_q;
  logic [1:0]    size_q;
  logic          sext_q;
  logic [31:0]   wdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   cur_word;
  logic [31:0]   merged_word;
  logic [31:0]   read_data;

  assign accept   = (state == IDLE) && req;
  assign cur_word = mem[idx_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter restarts from zero on every entry to WAIT, so each transaction sees the full delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && (state_next == WAIT)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      off_q   <= '0;
      rw_q    <= READ;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= addr[AW+1:2];
      off_q   <= addr[1:0];
      rw_q    <= rw;
      size_q  <= size;
      sext_q  <= sign_ext;
      wdata_q <= wdata;
      err_q   <= misaligned(size, addr[1:0]) || (addr >= MEM_BYTES);
    end
  end

  dmem_lane_align u_align (
    .size        (size_q),
    .sign_ext    (sext_q),
    .offset      (off_q),
    .old_word    (cur_word),
    .wdata       (wdata_q),
    .merged_word (merged_word),
    .read_data   (read_data)
  );

  // Storage is deliberately left out of reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if ((state == ACCESS) && (rw_q == WRITE) && !err_q) begin
      mem[idx_q] <= merged_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (state == ACCESS) begin
      if (err_q)              rdata <= '0;
      else if (rw_q == READ)  rdata <= read_data;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = (state == DONE) && err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: a byte-addressed big-endian reference model predicts each
// completion, and a monitor compares every done pulse against the queued expectation.
module tb_data_mem_unit;
  import dmem_pkg::*;

  localparam int DEPTH = 64;
  localparam int WC    = 1;
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req;
  logic        rw;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  int          checks;
  int          fails;
  int          cyc;
  int          done_cnt;
  int          pushed;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  mb [0:DEPTH*4-1];
  logic [31:0] model_rd;

  data_mem_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .rw       (rw),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: memory as a flat byte array, most significant byte at the lowest address.
  function automatic void model(input logic r_w, input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    n  = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    er = (sz == SZ_ILLEGAL) || (sz == SZ_HALF && a[0]) ||
         (sz == SZ_WORD && a[1:0] != 2'b00) || (a >= MEM_BYTES);
    if (er) begin
      model_rd = 32'h0;
    end else if (r_w == WRITE) begin
      for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*(n-1-i) +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mb[int'(a) + i]};
      if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      model_rd = v;
    end
    rd = model_rd;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_done: done=1 with no transaction pending (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rdata", rdata, mon_e.rdata);
        checkOutput("err", {31'h0, err}, {31'h0, mon_e.err});
        checkOutput("latency", 32'(cyc - mon_e.acc), 32'(WC + 1));
      end
    end
  end

  task automatic waitIdle();
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (!busy && sb.size() == 0) return;
    end
    checks++;
    fails++;
    $display("[TB] FAIL wait_idle: busy=%0b pending=%0d, required idle with none pending", busy, sb.size());
    sb.delete();
  endtask

  // Issues one request from IDLE; optional golden value overrides the model for directed cases.
  task automatic applyStimulus(input logic r_w, input logic [1:0] sz, input logic sx,
                               input logic [31:0] a, input logic [31:0] wd,
                               input bit use_gold, input logic [31:0] gold, input bit stray);
    exp_t e;
    logic [31:0] mrd;
    logic mer;
    @(negedge clk);
    req = 1'b1; rw = r_w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    checkOutput("busy_after_accept", {31'h0, busy}, 32'd1);
    model(r_w, sz, sx, a, wd, mrd, mer);
    e.rdata = use_gold ? gold : mrd;
    e.err   = mer;
    e.acc   = cyc;
    sb.push_back(e);
    pushed++;
    req = 1'b0; rw = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    if (stray) begin
      @(negedge clk);
      req = 1'b1; rw = WRITE; size = SZ_WORD; addr = 32'h0000_0010; wdata = 32'hBAD0_BAD0;
      @(negedge clk);
      req = 1'b0;
    end
    waitIdle();
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    checks = 0; fails = 0; done_cnt = 0; pushed = 0; model_rd = 32'h0;
    reset = 1'b1; req = 1'b0; rw = READ; size = SZ_WORD; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0;

    repeat (3) begin
      @(negedge clk);
      req = 1'($urandom); addr = $urandom;
    end
    #1;
    checkOutput("reset_busy", {31'h0, busy}, 32'd0);
    checkOutput("reset_done", {31'h0, done}, 32'd0);
    checkOutput("reset_err", {31'h0, err}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'h0);
    @(negedge clk);
    req = 1'b0;
    reset = 1'b0;

    for (int w = 0; w < DEPTH; w++)
      applyStimulus(WRITE, SZ_WORD, 1'b0, 32'(w * 4), $urandom, 1'b0, 32'h0, 1'b0);

    applyStimulus(WRITE, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    applyStimulus(READ,  SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(WRITE, SZ_BYTE, 1'b0, 32'h11, 32'h55, 1'b0, 32'h0, 1'b0);
    applyStimulus(READ,  SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDE55_BEEF, 1'b0);
    applyStimulus(READ,  SZ_BYTE, 1'b1, 32'h10, 32'h0, 1'b1, 32'hFFFF_FFDE, 1'b0);
    applyStimulus(READ,  SZ_BYTE, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0000_00DE, 1'b0);
    applyStimulus(READ,  SZ_HALF, 1'b1, 32'h12, 32'h0, 1'b1, 32'hFFFF_BEEF, 1'b0);
    applyStimulus(WRITE, SZ_WORD, 1'b0, 32'h14, 32'h0, 1'b1, 32'hFFFF_BEEF, 1'b0);

    applyStimulus(READ,  SZ_HALF, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b0);
    applyStimulus(READ,  SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDE55_BEEF, 1'b0);
    applyStimulus(WRITE, SZ_WORD, 1'b0, 32'h102, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0);
    applyStimulus(READ,  SZ_ILLEGAL, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0);
    applyStimulus(READ,  SZ_WORD, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b0);
    applyStimulus(READ,  SZ_WORD, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0, 1'b0);

    applyStimulus(READ,  SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDE55_BEEF, 1'b1);
    applyStimulus(READ,  SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDE55_BEEF, 1'b0);

    // Abandon a write while it is still waiting; nothing may complete or be committed.
    @(negedge clk);
    req = 1'b1; rw = WRITE; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h20; wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    req = 1'b0;
    checkOutput("busy_before_abort", {31'h0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", {31'h0, busy}, 32'd0);
    checkOutput("abort_done", {31'h0, done}, 32'd0);
    checkOutput("abort_err", {31'h0, err}, 32'd0);
    checkOutput("abort_rdata", rdata, 32'h0);
    model_rd = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(READ, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else                           a = 32'($urandom_range(0, DEPTH * 4 + 7));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_HALF) a[0] = 1'b0;
        if (sz == SZ_WORD) a[1:0] = 2'b00;
      end
      applyStimulus(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0, 32'h0,
                    ($urandom_range(0, 7) == 0));
    end

    waitIdle();
    checkOutput("done_count", 32'(done_cnt), 32'(pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
